id_stage_v2: RTL and testbench

Parametrised decode stage that sits between the fetch pipeline register and EX. It generalises the existing decode stage: configurable widths, an internal register file with same-cycle write-through instead of negative-edge writes, and load-use/branch-operand hazard detection with stall and bubble insertion. It also provides a valid bit and a downstream hold. It resolves jumps and branches in ID and drives the next-PC redirect to fetch.

---
 rtl/id_pkg.sv | 27 ++
 rtl/id_regfile.sv | 50 +++++
 rtl/id_stage_v2.sv | 209 ++++++++++++++++++++
 tb/tb_id_stage_v2.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: branch encodings, id_ctrl field slices,
// and the fill value used for bubbled control bundles.
package id_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  // id_ctrl_i = {jmp, npc_from_gpr, branch_type[2:0], extop, exsign}
  localparam int CTRL_JMP     = 6;
  localparam int CTRL_NPC_GPR = 5;
  localparam int CTRL_BR_HI   = 4;
  localparam int CTRL_BR_LO   = 2;
  localparam int CTRL_EXTOP   = 1;
  localparam int CTRL_EXSIGN  = 0;

  // Every bit of a bubbled control bundle takes this value.
  localparam logic BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/id_regfile.sv
// 2-read 1-write register file. r0 reads zero and never stores; a write
// and a read of the same register in one cycle return the new data.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RA_W-1:0] wa,
  input  logic [XLEN-1:0] wd
);

  localparam int NREG = 1 << RA_W;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents: one write per cycle, r0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (we && wa != '0) regs_d[wa] = wd;
  end

  // Storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with write-through of the in-flight write.
  always_comb begin
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
    if (we && wa != '0 && wa == ra1) rd1 = wd;
    if (we && wa != '0 && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/id_stage_v2.sv
// Decode stage: register read with MEM/WB forwarding, immediate extension,
// in-ID branch/jump resolution, hazard stall/bubble, and the ID/EX register.
module id_stage_v2
  import id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int EX_CTRL_W = 14,
  parameter int WB_CTRL_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic [XLEN-3:0]      id_pcp1_i,
  input  logic [31:0]          id_instr_i,
  input  logic [6:0]           id_ctrl_i,
  input  logic [EX_CTRL_W-1:0] ex_ctrl_i,
  input  logic                 mem_ctrl_i,
  input  logic [WB_CTRL_W-1:0] wb_ctrl_i,
  input  logic                 flush_i,
  input  logic                 ex_hold_i,
  input  logic                 ex_we_i,
  input  logic                 ex_load_i,
  input  logic [RA_W-1:0]      ex_rw_i,
  input  logic                 mem_we_i,
  input  logic [RA_W-1:0]      mem_rw_i,
  input  logic [XLEN-1:0]      mem_wd_i,
  input  logic                 wb_we_i,
  input  logic [RA_W-1:0]      wb_rw_i,
  input  logic [XLEN-1:0]      wb_wd_i,
  output logic                 stall_o,
  output logic                 redirect_o,
  output logic [XLEN-3:0]      npc_o,
  output logic                 ex_valid_o,
  output logic [EX_CTRL_W-1:0] ex_ctrl_o,
  output logic                 mem_ctrl_o,
  output logic [WB_CTRL_W-1:0] wb_ctrl_o,
  output logic [XLEN-3:0]      ex_pcp1_o,
  output logic [31:0]          ex_instr_o,
  output logic [XLEN-1:0]      ex_rd1_o,
  output logic [XLEN-1:0]      ex_rd2_o,
  output logic [XLEN-1:0]      ex_ext_o
);

  logic [RA_W-1:0] rs, rt;
  logic [15:0]     imm;
  logic            jmp, jr, extop, exsign;
  br_type_e        br;
  logic [XLEN-1:0] rf_rd1, rf_rd2, f_rd1, f_rd2, ext;
  logic            taken, hazard;
  logic [XLEN-3:0] br_off;
  logic            unused_opcode;

  assign rs     = RA_W'(id_instr_i[25:21]);
  assign rt     = RA_W'(id_instr_i[20:16]);
  assign imm    = id_instr_i[15:0];
  assign jmp    = id_ctrl_i[CTRL_JMP];
  assign jr     = id_ctrl_i[CTRL_NPC_GPR];
  assign br     = br_type_e'(id_ctrl_i[CTRL_BR_HI:CTRL_BR_LO]);
  assign extop  = id_ctrl_i[CTRL_EXTOP];
  assign exsign = id_ctrl_i[CTRL_EXSIGN];
  // Opcode is decoded upstream into id_ctrl_i.
  assign unused_opcode = ^id_instr_i[31:26];

  id_regfile #(.XLEN(XLEN), .RA_W(RA_W)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_we_i),
    .wa  (wb_rw_i),
    .wd  (wb_wd_i)
  );

  // Operand forwarding: MEM is younger than WB so it wins.
  always_comb begin
    f_rd1 = rf_rd1;
    f_rd2 = rf_rd2;
    if (mem_we_i && mem_rw_i != '0 && mem_rw_i == rs)     f_rd1 = mem_wd_i;
    else if (wb_we_i && wb_rw_i != '0 && wb_rw_i == rs)   f_rd1 = wb_wd_i;
    if (mem_we_i && mem_rw_i != '0 && mem_rw_i == rt)     f_rd2 = mem_wd_i;
    else if (wb_we_i && wb_rw_i != '0 && wb_rw_i == rt)   f_rd2 = wb_wd_i;
  end

  // Immediate extension; extop without exsign is lui (imm in bits 31:16).
  always_comb begin
    ext = XLEN'(imm);
    if (extop) begin
      if (exsign) ext = {{(XLEN-16){imm[15]}}, imm};
      else        ext = XLEN'(imm) << 16;
    end
  end

  // Branch condition, signed, on forwarded operands.
  always_comb begin
    taken = 1'b0;
    case (br)
      BR_BEQ:  taken = (f_rd1 == f_rd2);
      BR_BNE:  taken = (f_rd1 != f_rd2);
      BR_BLEZ: taken = f_rd1[XLEN-1] | (f_rd1 == '0);
      BR_BGTZ: taken = ~f_rd1[XLEN-1] & (f_rd1 != '0);
      BR_BLTZ: taken = f_rd1[XLEN-1];
      BR_BGEZ: taken = ~f_rd1[XLEN-1];
      default: taken = 1'b0;
    endcase
  end

  // Next PC: jump > register jump > taken branch > fall-through.
  always_comb begin
    br_off = {{(XLEN-18){imm[15]}}, imm};
    npc_o  = id_pcp1_i;
    if (jmp)        npc_o = {id_pcp1_i[XLEN-3:26], id_instr_i[25:0]};
    else if (jr)    npc_o = f_rd1[XLEN-1:2];
    else if (taken) npc_o = id_pcp1_i + br_off;
  end

  // Hazards against the instruction in EX: load-use for any operand, and
  // any EX writer for operands consumed in ID (jr target, branch compare).
  always_comb begin
    logic rs_ex, rt_ex, ctl_rs, ctl_rt;
    rs_ex  = (ex_rw_i != '0) && (rs == ex_rw_i);
    rt_ex  = (ex_rw_i != '0) && (rt == ex_rw_i);
    ctl_rs = jr || (br != BR_NONE && br != BR_RSVD);
    ctl_rt = (br == BR_BEQ) || (br == BR_BNE);
    hazard = id_valid_i &&
             ((ex_load_i && (rs_ex || rt_ex)) ||
              (ex_we_i && ((ctl_rs && rs_ex) || (ctl_rt && rt_ex))));
  end

  assign stall_o    = hazard | ex_hold_i;
  assign redirect_o = id_valid_i & ~stall_o & ~flush_i & (jmp | jr | taken);

  logic                 ex_valid_q, ex_valid_d;
  logic [EX_CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic                 mem_ctrl_q, mem_ctrl_d;
  logic [WB_CTRL_W-1:0] wb_ctrl_q, wb_ctrl_d;
  logic [XLEN-3:0]      ex_pcp1_q, ex_pcp1_d;
  logic [31:0]          ex_instr_q, ex_instr_d;
  logic [XLEN-1:0]      ex_rd1_q, ex_rd1_d, ex_rd2_q, ex_rd2_d, ex_ext_q, ex_ext_d;

  // ID/EX next state: hold > flush/hazard bubble > load. Bubbles keep data.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    wb_ctrl_d  = wb_ctrl_q;
    ex_pcp1_d  = ex_pcp1_q;
    ex_instr_d = ex_instr_q;
    ex_rd1_d   = ex_rd1_q;
    ex_rd2_d   = ex_rd2_q;
    ex_ext_d   = ex_ext_q;
    if (ex_hold_i) begin
      // keep everything
    end else if (flush_i || hazard) begin
      ex_valid_d = BUBBLE_CTRL;
      ex_ctrl_d  = {EX_CTRL_W{BUBBLE_CTRL}};
      mem_ctrl_d = BUBBLE_CTRL;
      wb_ctrl_d  = {WB_CTRL_W{BUBBLE_CTRL}};
    end else begin
      ex_valid_d = id_valid_i;
      ex_ctrl_d  = ex_ctrl_i;
      mem_ctrl_d = mem_ctrl_i;
      wb_ctrl_d  = wb_ctrl_i;
      ex_pcp1_d  = id_pcp1_i;
      ex_instr_d = id_instr_i;
      ex_rd1_d   = f_rd1;
      ex_rd2_d   = f_rd2;
      ex_ext_d   = ext;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= 1'b0;
      wb_ctrl_q  <= '0;
      ex_pcp1_q  <= '0;
      ex_instr_q <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_ext_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      wb_ctrl_q  <= wb_ctrl_d;
      ex_pcp1_q  <= ex_pcp1_d;
      ex_instr_q <= ex_instr_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_ext_q   <= ex_ext_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_ctrl_o  = ex_ctrl_q;
  assign mem_ctrl_o = mem_ctrl_q;
  assign wb_ctrl_o  = wb_ctrl_q;
  assign ex_pcp1_o  = ex_pcp1_q;
  assign ex_instr_o = ex_instr_q;
  assign ex_rd1_o   = ex_rd1_q;
  assign ex_rd2_o   = ex_rd2_q;
  assign ex_ext_o   = ex_ext_q;

endmodule

// File: tb/tb_id_stage_v2.sv
// Scoreboarded bench for id_stage_v2: expected ID/EX contents are queued
// when a cycle is driven and compared after the following posedge.
module tb_id_stage_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [29:0] id_pcp1_i;
  logic [31:0] id_instr_i;
  logic [6:0]  id_ctrl_i;
  logic [13:0] ex_ctrl_i;
  logic        mem_ctrl_i;
  logic [4:0]  wb_ctrl_i;
  logic        flush_i, ex_hold_i;
  logic        ex_we_i, ex_load_i;
  logic [4:0]  ex_rw_i;
  logic        mem_we_i;
  logic [4:0]  mem_rw_i;
  logic [31:0] mem_wd_i;
  logic        wb_we_i;
  logic [4:0]  wb_rw_i;
  logic [31:0] wb_wd_i;
  logic        stall_o, redirect_o;
  logic [29:0] npc_o;
  logic        ex_valid_o;
  logic [13:0] ex_ctrl_o;
  logic        mem_ctrl_o;
  logic [4:0]  wb_ctrl_o;
  logic [29:0] ex_pcp1_o;
  logic [31:0] ex_instr_o, ex_rd1_o, ex_rd2_o, ex_ext_o;

  id_stage_v2 dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_pcp1_i(id_pcp1_i),
    .id_instr_i(id_instr_i), .id_ctrl_i(id_ctrl_i), .ex_ctrl_i(ex_ctrl_i),
    .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i), .flush_i(flush_i),
    .ex_hold_i(ex_hold_i), .ex_we_i(ex_we_i), .ex_load_i(ex_load_i),
    .ex_rw_i(ex_rw_i), .mem_we_i(mem_we_i), .mem_rw_i(mem_rw_i),
    .mem_wd_i(mem_wd_i), .wb_we_i(wb_we_i), .wb_rw_i(wb_rw_i),
    .wb_wd_i(wb_wd_i), .stall_o(stall_o), .redirect_o(redirect_o),
    .npc_o(npc_o), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
    .mem_ctrl_o(mem_ctrl_o), .wb_ctrl_o(wb_ctrl_o), .ex_pcp1_o(ex_pcp1_o),
    .ex_instr_o(ex_instr_o), .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o),
    .ex_ext_o(ex_ext_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [13:0] ex;
    logic        mem;
    logic [4:0]  wb;
    logic        chk_rd;
    logic [31:0] rd1, rd2;
    logic        chk_ext;
    logic [31:0] ext;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic void push_ld(input string nm, input logic [13:0] ex, input logic mem,
                                  input logic [4:0] wb, input logic [31:0] rd1, input logic [31:0] rd2);
    exp_t e;
    e.name = nm; e.v = 1'b1; e.ex = ex; e.mem = mem; e.wb = wb;
    e.chk_rd = 1'b1; e.rd1 = rd1; e.rd2 = rd2; e.chk_ext = 1'b0; e.ext = '0;
    sb.push_back(e);
  endfunction

  function automatic void push_bub(input string nm, input logic chk, input logic [31:0] rd1,
                                   input logic [31:0] rd2);
    exp_t e;
    e.name = nm; e.v = 1'b0; e.ex = '0; e.mem = 1'b0; e.wb = '0;
    e.chk_rd = chk; e.rd1 = rd1; e.rd2 = rd2; e.chk_ext = 1'b0; e.ext = '0;
    sb.push_back(e);
  endfunction

  // Advance one cycle and score the entry queued for it, if any.
  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (ex_valid_o !== e.v || ex_ctrl_o !== e.ex || mem_ctrl_o !== e.mem || wb_ctrl_o !== e.wb) begin
        n_fail++;
        $display("FAIL %s ctrl: got v=%0b ex=%h mem=%0b wb=%h, want v=%0b ex=%h mem=%0b wb=%h",
                 e.name, ex_valid_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, e.v, e.ex, e.mem, e.wb);
      end
      if (e.chk_rd) begin
        n_tests++;
        if (ex_rd1_o !== e.rd1 || ex_rd2_o !== e.rd2) begin
          n_fail++;
          $display("FAIL %s data: got rd1=%h rd2=%h, want rd1=%h rd2=%h",
                   e.name, ex_rd1_o, ex_rd2_o, e.rd1, e.rd2);
        end
      end
      if (e.chk_ext) begin
        n_tests++;
        if (ex_ext_o !== e.ext) begin
          n_fail++;
          $display("FAIL %s ext: got %h, want %h", e.name, ex_ext_o, e.ext);
        end
      end
    end
  endtask

  task automatic idle();
    id_valid_i = 0; id_pcp1_i = '0; id_instr_i = '0; id_ctrl_i = '0;
    ex_ctrl_i = '0; mem_ctrl_i = 0; wb_ctrl_i = '0; flush_i = 0; ex_hold_i = 0;
    ex_we_i = 0; ex_load_i = 0; ex_rw_i = '0;
    mem_we_i = 0; mem_rw_i = '0; mem_wd_i = '0;
    wb_we_i = 0; wb_rw_i = '0; wb_wd_i = '0;
  endtask

  task automatic wb_write(input logic [4:0] rw, input logic [31:0] wd);
    idle();
    wb_we_i = 1; wb_rw_i = rw; wb_wd_i = wd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 0; idle();
    #3;
    n_tests++;
    if (ex_valid_o !== 0 || ex_ctrl_o !== 0 || wb_ctrl_o !== 0 || ex_rd1_o !== 0 || ex_pcp1_o !== 0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b ex=%h wb=%h rd1=%h pc=%h, want all zero",
               ex_valid_o, ex_ctrl_o, wb_ctrl_o, ex_rd1_o, ex_pcp1_o);
    end
    @(negedge clk); rst = 1;
  endtask

  task automatic test_load_use();
    idle();
    id_valid_i = 1; id_instr_i = mk(6'h00, 5'd3, 5'd1, 16'h2020);
    ex_ctrl_i = 14'h02A; wb_ctrl_i = 5'h03;
    ex_we_i = 1; ex_load_i = 1; ex_rw_i = 5'd3;
    #1; n_tests++;
    if (stall_o !== 1 || redirect_o !== 0) begin
      n_fail++; $display("FAIL load_use_stall: got stall=%0b redir=%0b, want 1 0", stall_o, redirect_o);
    end
    push_bub("load_use_bubble", 1'b0, '0, '0);
    tick();
    ex_we_i = 0; ex_load_i = 0; ex_rw_i = '0;
    mem_we_i = 1; mem_rw_i = 5'd3; mem_wd_i = 32'h1234;
    #1; n_tests++;
    if (stall_o !== 0) begin
      n_fail++; $display("FAIL load_use_release: got stall=%0b, want 0", stall_o);
    end
    push_ld("load_use_fwd", 14'h02A, 1'b0, 5'h03, 32'h1234, 32'h11);
    tick();
    idle();
  endtask

  task automatic test_beq_after_alu();
    idle();
    id_valid_i = 1; id_pcp1_i = 30'h100; id_ctrl_i = 7'h07;
    id_instr_i = mk(6'h04, 5'd2, 5'd2, 16'h0004);
    ex_we_i = 1; ex_rw_i = 5'd2; ex_ctrl_i = 14'h111;
    #1; n_tests++;
    if (stall_o !== 1 || redirect_o !== 0) begin
      n_fail++; $display("FAIL beq_stall: got stall=%0b redir=%0b, want 1 0", stall_o, redirect_o);
    end
    push_bub("beq_bubble", 1'b0, '0, '0);
    tick();
    ex_we_i = 0; ex_rw_i = '0;
    mem_we_i = 1; mem_rw_i = 5'd2; mem_wd_i = 32'h77;
    #1; n_tests++;
    if (stall_o !== 0 || redirect_o !== 1 || npc_o !== 30'h104) begin
      n_fail++; $display("FAIL beq_redirect: got stall=%0b redir=%0b npc=%h, want 0 1 104",
                         stall_o, redirect_o, npc_o);
    end
    push_ld("beq_issue", 14'h111, 1'b0, 5'h0, 32'h77, 32'h77);
    tick();
    idle();
  endtask

  task automatic test_branch_types();
    logic [2:0]  bt [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
    logic [31:0] av [8] = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
    logic [31:0] bv [8] = '{32'd5, 32'd5, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        tk [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [29:0] want;
    for (int i = 0; i < 8; i++) begin
      idle();
      id_valid_i = 1; id_pcp1_i = 30'h200; id_ctrl_i = {2'b00, bt[i], 2'b11};
      id_instr_i = mk(6'h04, 5'd6, 5'd8, 16'hFFFE);
      mem_we_i = 1; mem_rw_i = 5'd6; mem_wd_i = av[i];
      wb_we_i = 1; wb_rw_i = 5'd8; wb_wd_i = bv[i];
      want = tk[i] ? 30'h1FE : 30'h200;
      #1; n_tests++;
      if (redirect_o !== tk[i] || npc_o !== want) begin
        n_fail++; $display("FAIL branch_type_%0d: got redir=%0b npc=%h, want %0b %h",
                           bt[i], redirect_o, npc_o, tk[i], want);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_jump();
    idle();
    id_valid_i = 1; id_ctrl_i = 7'h40; id_pcp1_i = 30'h3C00_0010;
    id_instr_i = {6'h02, 26'h000_0ABC};
    #1; n_tests++;
    if (redirect_o !== 1 || npc_o !== 30'h3C00_0ABC) begin
      n_fail++; $display("FAIL jmp: got redir=%0b npc=%h, want 1 3c000abc", redirect_o, npc_o);
    end
    tick();
    id_ctrl_i = 7'h20; id_instr_i = mk(6'h00, 5'd6, 5'd0, 16'h0008);
    mem_we_i = 1; mem_rw_i = 5'd6; mem_wd_i = 32'h1000;
    #1; n_tests++;
    if (redirect_o !== 1 || npc_o !== 30'h400) begin
      n_fail++; $display("FAIL jr: got redir=%0b npc=%h, want 1 400", redirect_o, npc_o);
    end
    tick();
    ex_we_i = 1; ex_rw_i = 5'd6;
    #1; n_tests++;
    if (stall_o !== 1 || redirect_o !== 0) begin
      n_fail++; $display("FAIL jr_hazard: got stall=%0b redir=%0b, want 1 0", stall_o, redirect_o);
    end
    tick();
    ex_we_i = 0; ex_rw_i = '0; flush_i = 1;
    #1; n_tests++;
    if (stall_o !== 0 || redirect_o !== 0) begin
      n_fail++; $display("FAIL jr_flush: got stall=%0b redir=%0b, want 0 0", stall_o, redirect_o);
    end
    tick();
    idle();
  endtask

  task automatic test_ext();
    logic [1:0]  eo [4] = '{2'b00, 2'b11, 2'b10, 2'b11};
    logic [15:0] im [4] = '{16'h8000, 16'h8000, 16'h1234, 16'h7FFF};
    logic [31:0] ev [4] = '{32'h0000_8000, 32'hFFFF_8000, 32'h1234_0000, 32'h0000_7FFF};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      idle();
      id_valid_i = 1; id_ctrl_i = {5'b0, eo[i]}; id_instr_i = mk(6'h08, 5'd0, 5'd0, im[i]);
      e.name = "ext"; e.v = 1; e.ex = '0; e.mem = 0; e.wb = '0;
      e.chk_rd = 0; e.rd1 = '0; e.rd2 = '0; e.chk_ext = 1; e.ext = ev[i];
      sb.push_back(e);
      tick();
    end
    idle();
  endtask

  task automatic test_fwd_priority();
    idle();
    id_valid_i = 1; id_pcp1_i = 30'h0ABC; id_instr_i = mk(6'h00, 5'd7, 5'd0, 16'h3820);
    ex_ctrl_i = 14'h0F0; mem_ctrl_i = 1; wb_ctrl_i = 5'h11;
    mem_we_i = 1; mem_rw_i = 5'd7; mem_wd_i = 32'hA;
    wb_we_i = 1; wb_rw_i = 5'd7; wb_wd_i = 32'hB;
    push_ld("fwd_mem_over_wb", 14'h0F0, 1'b1, 5'h11, 32'hA, 32'h0);
    tick();
    n_tests++;
    if (ex_pcp1_o !== 30'h0ABC || ex_instr_o !== 32'h00E0_3820) begin
      n_fail++; $display("FAIL ex_pc_instr: got pc=%h instr=%h, want 0abc 00e03820", ex_pcp1_o, ex_instr_o);
    end
    mem_we_i = 0; wb_we_i = 0;
    push_ld("wb_landed", 14'h0F0, 1'b1, 5'h11, 32'hB, 32'h0);
    tick();
    idle();
  endtask

  task automatic test_wb_writethrough();
    idle();
    id_valid_i = 1; id_instr_i = mk(6'h00, 5'd0, 5'd9, 16'h0);
    wb_we_i = 1; wb_rw_i = 5'd9; wb_wd_i = 32'h55;
    push_ld("wb_through", 14'h0, 1'b0, 5'h0, 32'h0, 32'h55);
    tick();
    id_instr_i = mk(6'h00, 5'd0, 5'd0, 16'h0);
    wb_rw_i = 5'd0; wb_wd_i = 32'hDEAD;
    push_ld("r0_write_same", 14'h0, 1'b0, 5'h0, 32'h0, 32'h0);
    tick();
    wb_we_i = 0; id_instr_i = mk(6'h00, 5'd9, 5'd0, 16'h0);
    push_ld("r9_stored", 14'h0, 1'b0, 5'h0, 32'h55, 32'h0);
    tick();
    idle();
  endtask

  task automatic test_hold_flush();
    idle();
    id_valid_i = 1; id_instr_i = mk(6'h00, 5'd1, 5'd0, 16'h0);
    ex_ctrl_i = 14'h155; mem_ctrl_i = 1; wb_ctrl_i = 5'h15;
    push_ld("hf_load", 14'h155, 1'b1, 5'h15, 32'h11, 32'h0);
    tick();
    ex_hold_i = 1; flush_i = 1;
    ex_ctrl_i = 14'h0AA; mem_ctrl_i = 0; wb_ctrl_i = 5'h0A;
    id_instr_i = mk(6'h00, 5'd5, 5'd0, 16'h0);
    #1; n_tests++;
    if (stall_o !== 1) begin
      n_fail++; $display("FAIL hold_stall: got stall=%0b, want 1", stall_o);
    end
    push_ld("hold_over_flush", 14'h155, 1'b1, 5'h15, 32'h11, 32'h0);
    tick();
    ex_hold_i = 0;
    #1; n_tests++;
    if (stall_o !== 0 || redirect_o !== 0) begin
      n_fail++; $display("FAIL flush_nostall: got stall=%0b redir=%0b, want 0 0", stall_o, redirect_o);
    end
    push_bub("flush_bubble", 1'b1, 32'h11, 32'h0);
    tick();
    ex_load_i = 1; ex_we_i = 1; ex_rw_i = 5'd5;
    #1; n_tests++;
    if (stall_o !== 1) begin
      n_fail++; $display("FAIL flush_hazard_stall: got stall=%0b, want 1", stall_o);
    end
    push_bub("flush_hazard_bubble", 1'b1, 32'h11, 32'h0);
    tick();
    idle();
  endtask

  task automatic test_reset_midrun();
    idle();
    id_valid_i = 1; id_instr_i = mk(6'h00, 5'd5, 5'd0, 16'h0); ex_ctrl_i = 14'h3FFF;
    push_ld("pre_reset", 14'h3FFF, 1'b0, 5'h0, 32'h5555, 32'h0);
    tick();
    #2 rst = 0;
    #1; n_tests++;
    if (ex_valid_o !== 0 || ex_ctrl_o !== 0 || ex_rd1_o !== 0 || ex_instr_o !== 0) begin
      n_fail++; $display("FAIL midrun_reset: got v=%0b ex=%h rd1=%h instr=%h, want all zero",
                         ex_valid_o, ex_ctrl_o, ex_rd1_o, ex_instr_o);
    end
    @(negedge clk); rst = 1;
    push_ld("r5_cleared", 14'h3FFF, 1'b0, 5'h0, 32'h0, 32'h0);
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    wb_write(5'd1, 32'h11);
    wb_write(5'd5, 32'h5555);
    test_load_use();
    test_beq_after_alu();
    test_branch_types();
    test_jump();
    test_ext();
    test_fwd_priority();
    test_wb_writethrough();
    test_hold_flush();
    test_reset_midrun();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
